// File: rtl/fp_norm_pkg.sv
// -----------------------------------------------------------------------------
// fp_norm_pkg
//   Shared definitions for the floating-point mantissa normalizer.
//   - Default exponent / mantissa widths.
//   - Bit positions of the fields in the operand A and in the result fnum.
//     These are given for the default widths.
//   - Width of the shift-amount counter.
//   - FSM state enum.
// -----------------------------------------------------------------------------
package fp_norm_pkg;

    // Default field widths. The mantissa width includes the explicit leading bit.
    localparam int EXP_W_D = 8;
    localparam int MAN_W_D = 24;

    // Operand A layout: {sign, exponent, mantissa}. It is 33 bits wide.
    localparam int A_W        = 1 + EXP_W_D + MAN_W_D;
    localparam int A_SIGN_BIT = EXP_W_D + MAN_W_D;        // 32
    localparam int A_EXP_HI   = EXP_W_D + MAN_W_D - 1;    // 31
    localparam int A_EXP_LO   = MAN_W_D;                  // 24
    localparam int A_MAN_HI   = MAN_W_D - 1;              // 23
    localparam int A_MAN_LO   = 0;

    // Result fnum layout: {sign, exponent, mantissa without leading bit}.
    // It is 32 bits wide.
    localparam int F_W        = EXP_W_D + MAN_W_D;
    localparam int F_SIGN_BIT = EXP_W_D + MAN_W_D - 1;    // 31
    localparam int F_EXP_HI   = EXP_W_D + MAN_W_D - 2;    // 30
    localparam int F_EXP_LO   = MAN_W_D - 1;              // 23
    localparam int F_MAN_HI   = MAN_W_D - 2;              // 22
    localparam int F_MAN_LO   = 0;

    // Shift counter width. A 24-bit mantissa needs at most 23 shifts.
    localparam int SHAMT_W = 5;

    // Controller states. "done" is a registered pulse and is not a state.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        NORM = 1'b1
    } state_t;

endpackage : fp_norm_pkg

// File: rtl/fp_norm_step.sv
// -----------------------------------------------------------------------------
// fp_norm_step
//   Combinational single normalization step, used by fp_norm_ctrl.
//   Given the working mantissa and exponent, this module:
//   - Produces the candidate next values: the mantissa shifted left by one
//     with zero fill, and the exponent minus one.
//   - Produces the three termination tests for the current values.
//
// Ports
//   man       in   MAN_W   working mantissa (leading bit included)
//   exp       in   EXP_W   working exponent (unsigned)
//   man_sh    out  MAN_W   man << 1, zero fill
//   exp_dec   out  EXP_W   exp - 1
//   lead      out  1       leading bit of man is set (already normalized)
//   man_zero  out  1       man is all zeros
//   exp_zero  out  1       exp is zero (no room left to shift)
// -----------------------------------------------------------------------------
module fp_norm_step
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = EXP_W_D,
    parameter int MAN_W = MAN_W_D
) (
    input  logic [MAN_W-1:0] man,
    input  logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] man_sh,
    output logic [EXP_W-1:0] exp_dec,
    output logic             lead,
    output logic             man_zero,
    output logic             exp_zero
);

    assign man_sh   = {man[MAN_W-2:0], 1'b0};

    // The controller uses exp_dec only when exp_zero is clear,
    // so this subtraction never wraps below zero.
    assign exp_dec  = exp - EXP_W'(1);

    assign lead     = man[MAN_W-1];
    assign man_zero = (man == '0);
    assign exp_zero = (exp == '0);

endmodule : fp_norm_step

// File: rtl/fp_norm_ctrl.sv
// -----------------------------------------------------------------------------
// fp_norm_ctrl
//   Multi-cycle normalizer for a sign/exponent/mantissa operand.
//
//   In IDLE, a start pulse latches the operand A. The controller then moves
//   to NORM. In NORM, the termination tests are evaluated first, every cycle.
//   The operation terminates when any of these holds:
//   - the leading mantissa bit is set;
//   - the mantissa is zero;
//   - the exponent is zero.
//   On termination, the result registers are loaded, done pulses for one
//   cycle, and the FSM returns to IDLE on the same edge. Otherwise, the
//   mantissa shifts left by one, the exponent drops by one, and the shift
//   count goes up by one.
//
//   Timing: start is sampled in cycle 0. NORM occupies cycles 1..k+1, where
//   k is the number of shifts. done is high in cycle k+2.
//
//   Result encoding:
//   - Normalized:   {sign, exp, man[MAN_W-2:0]}, zero=0, underflow=0.
//   - Zero mantissa: {sign, 0, 0}, zero=1, underflow=0.
//   - Exponent ran out before the leading bit appeared:
//                   {sign, 0, shifted man[MAN_W-2:0]} (denormal), underflow=1.
//
//   Handshake: start is a request that is accepted only while the FSM is
//   IDLE (busy low). While busy is high, start is ignored and the latched
//   operand is not disturbed. done is a single-cycle valid strobe for fnum,
//   shamt, zero and underflow. There is no back-pressure. The result
//   registers hold their values until the next done.
//
// Ports
//   clk        in   1                rising-edge clock
//   rst        in   1                synchronous active-high reset
//   start      in   1                normalize request (IDLE only)
//   A          in   1+EXP_W+MAN_W    {sign, exponent, mantissa}
//   busy       out  1                operation in NORM
//   done       out  1                one-cycle result strobe
//   fnum       out  EXP_W+MAN_W      {sign, exponent, mantissa w/o leading bit}
//   shamt      out  SHAMT_W          left shifts applied
//   zero       out  1                input mantissa was zero
//   underflow  out  1                exponent hit 0 before leading bit set
//   state_dbg  out  state_t          current FSM state, for observation
// -----------------------------------------------------------------------------
module fp_norm_ctrl
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = EXP_W_D,
    parameter int MAN_W = MAN_W_D
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   A,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W-1:0] fnum,
    output logic [SHAMT_W-1:0]     shamt,
    output logic                   zero,
    output logic                   underflow,
    output state_t                 state_dbg
);

    // Field positions of A, derived from the parameters.
    localparam int SIGN_BIT = EXP_W + MAN_W;
    localparam int EXP_HI   = EXP_W + MAN_W - 1;
    localparam int EXP_LO   = MAN_W;

    // ------------------------------------------------------------------
    // Working registers
    // ------------------------------------------------------------------
    state_t             state;
    logic               sign_r;
    logic [EXP_W-1:0]   exp_r;
    logic [MAN_W-1:0]   man_r;
    logic [SHAMT_W-1:0] cnt_r;

    // ------------------------------------------------------------------
    // One-step datapath and termination tests
    // ------------------------------------------------------------------
    logic [MAN_W-1:0] man_sh;
    logic [EXP_W-1:0] exp_dec;
    logic             lead;
    logic             man_zero;
    logic             exp_zero;

    fp_norm_step #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_step (
        .man      (man_r),
        .exp      (exp_r),
        .man_sh   (man_sh),
        .exp_dec  (exp_dec),
        .lead     (lead),
        .man_zero (man_zero),
        .exp_zero (exp_zero)
    );

    // ------------------------------------------------------------------
    // FSM, counters and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fnum      <= '0;
            shamt     <= '0;
            zero      <= 1'b0;
            underflow <= 1'b0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            man_r     <= '0;
            cnt_r     <= '0;
        end else begin
            // done is a pulse. Clear it unless a termination re-asserts it below.
            done <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign_r <= A[SIGN_BIT];
                        exp_r  <= A[EXP_HI:EXP_LO];
                        man_r  <= A[MAN_W-1:0];
                        cnt_r  <= '0;
                        busy   <= 1'b1;
                        state  <= NORM;
                    end
                end

                NORM: begin
                    // The zero test comes first: a zero mantissa must report
                    // zero and not underflow, even when the exponent is also 0.
                    // The leading-bit test comes next: an operand that is
                    // already normalized with exponent 0 is not an underflow.
                    if (man_zero) begin
                        fnum      <= {sign_r, {(EXP_W+MAN_W-1){1'b0}}};
                        shamt     <= cnt_r;
                        zero      <= 1'b1;
                        underflow <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (lead) begin
                        fnum      <= {sign_r, exp_r, man_r[MAN_W-2:0]};
                        shamt     <= cnt_r;
                        zero      <= 1'b0;
                        underflow <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (exp_zero) begin
                        // Denormal result: exp_r is zero here, and the
                        // mantissa keeps the shifts applied so far.
                        fnum      <= {sign_r, {EXP_W{1'b0}}, man_r[MAN_W-2:0]};
                        shamt     <= cnt_r;
                        zero      <= 1'b0;
                        underflow <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        man_r <= man_sh;
                        exp_r <= exp_dec;
                        cnt_r <= cnt_r + SHAMT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule : fp_norm_ctrl

// File: doc/fp_norm_ctrl.md
FP_NORM_CTRL -- requirements
Module: fp_norm_ctrl

Interface
REQ-001 Parameter: EXP_W, 8, exponent width.
REQ-002 Parameter: MAN_W, 24, mantissa width including the explicit leading bit.
REQ-003 Port: clk  in  1  clock; all state changes on rising edge.
REQ-004 Port: rst  in  1  reset; one clock, synchronous, active-high.
REQ-005 Port: start  in  1  request to normalize A; sampled only in IDLE.
REQ-006 Port: A  in  1+EXP_W+MAN_W (33)  operand: [32] sign, [31:24] exponent, [23:0] mantissa.
REQ-007 Port: busy  out  1  high while the operation is in NORM.
REQ-008 Port: done  out  1  one-cycle pulse; fnum and flags valid.
REQ-009 Port: fnum  out  32  result: [31] sign, [30:23] exponent, [22:0] mantissa[22:0] (leading bit dropped).
REQ-010 Port: shamt  out  5  number of left shifts applied.
REQ-011 Port: zero  out  1  mantissa input was zero.
REQ-012 Port: underflow  out  1  exponent reached 0 before leading bit set.

Function
REQ-013 FSM states SHALL be IDLE and NORM only; done SHALL be a registered pulse, not a state.
REQ-014 In IDLE with start=1, the block SHALL latch sign, exponent and mantissa of A, clear shamt, and go to NORM.
REQ-015 start SHALL be ignored while in NORM; in-flight operands SHALL be unaffected.
REQ-016 Each NORM cycle SHALL first test the termination conditions: man[MAN_W-1]=1, or man=0, or exp=0.
REQ-017 On termination: capture fnum/shamt/zero/underflow, pulse done, and return to IDLE on the same edge.
REQ-018 Without termination, each NORM cycle SHALL shift man left by 1 with zero fill, decrement exp by 1, and increment shamt by 1.
REQ-019 Latency: done SHALL be high in cycle k+2 after the start cycle (cycle 0), where k is the number of shifts; maximum is 25.
REQ-020 Zero mantissa: fnum SHALL be {sign, 0, 0}, zero=1, underflow=0, shamt=0.
REQ-021 Exp reaching 0 with man[MAN_W-1]=0 and man≠0: fnum SHALL have exponent 0 and the shifted mantissa (denormal), underflow=1.
REQ-022 An operand already normalized SHALL pass with exponent and mantissa unchanged and shamt=0.
REQ-023 Exponent arithmetic SHALL be unsigned EXP_W bits and SHALL never wrap below 0, which REQ-016 guarantees.
REQ-024 fnum, shamt, zero and underflow SHALL hold their values from the last done until the next done.
REQ-025 The sign SHALL pass through unmodified in all cases.

Reset
REQ-026 rst=1 SHALL force state IDLE; busy, done, fnum, shamt, zero and underflow all 0 on the next edge.
REQ-027 rst during NORM SHALL abort the operation; no done SHALL be produced for it.
REQ-028 rst has priority over start on the same edge.

Structure
REQ-029 Package fp_norm_pkg SHALL hold EXP_W/MAN_W defaults, field bit positions of A/fnum, and the state enum.
REQ-030 The one-step shift/decrement logic SHALL be a combinational sub-module fp_norm_step (man, exp in; shifted man, exp−1 out).
REQ-031 The FSM, counters and output registers SHALL live in fp_norm_ctrl.

Verification
REQ-032 A={0,8'h80,24'h800000}, start in cycle 0 -> done in cycle 2, fnum=32'h40000000, shamt=0, zero=0, underflow=0.
REQ-033 A={0,8'h80,24'h000001} -> done in cycle 25, fnum=32'h34800000, shamt=23, busy high in cycles 1-24.
REQ-034 A={1,8'h55,24'h000000} -> done in cycle 2, fnum=32'h80000000, zero=1, shamt=0.
REQ-035 A={0,8'h03,24'h000100} -> done in cycle 5, fnum=32'h00000800, shamt=3, underflow=1.
REQ-036 Repeat the REQ-033 stimulus, pulse start with a new A in cycle 4 and assert rst in cycle 10 -> the second start is ignored, no done follows, and all outputs are 0 from cycle 11.
